mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the core's single external memory port (`MEM_*` bus) between the instruction-fetch requester (port 0) and the load/store requester (port 1, the memory controller's downstream side). It accepts level-held requests, grants one at a time with round-robin tie-breaking, and issues a single registered command per grant. It tracks the outstanding read until data returns and routes the completion to the granted port. A read that never completes is aborted by a timeout.

## Interface
- `TIMEOUT`, 255: max cycles spent in WAIT_READ before abort; 0 disables the timeout.
- `Clk` in 1: core clock; everything updates on rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `P0_Cmd`, `P1_Cmd` in 1: request, level; held with fields stable until matching `Px_Ack`.
- `P0_We`, `P1_We` in 1: 1 = write, 0 = read.
- `P0_ByteEnable`, `P1_ByteEnable` in 2: size code, passed through unchanged.
- `P0_Addr`, `P1_Addr` in 32: byte address.
- `P0_DataOut`, `P1_DataOut` in 32: write data.
- `P0_Ack`, `P1_Ack` out 1: one-cycle pulse; the request was issued to memory.
- `P0_DataIn`, `P1_DataIn` out 32: both are `MEM_DataIn` fanned out combinationally.
- `P0_DataReady`, `P1_DataReady` out 1: read data valid for that port.
- `MEM_Ready` in 1: memory can accept a command this cycle.
- `MEM_Cmd` out 1: registered one-cycle command strobe.
- `MEM_We`, `MEM_ByteEnable[1:0]`, `MEM_Addr[31:0]`, `MEM_DataOut[31:0]` out: registered command fields.
- `MEM_DataIn` in 32, `MEM_DataReady` in 1: read return.
- `Busy` out 1: state is not IDLE.
- `BusError` out 1: one-cycle pulse when a read times out.

## Operation
- **States:** IDLE, ISSUE, WAIT_READ. Reset forces IDLE; the `last` pointer is set to 1 so port 0 wins the first tie.
- **Reset values:** every output is 0.
- **IDLE:**
  - Arbitration runs only when `MEM_Ready`=1 and at least one `Px_Cmd`=1.
  - Winner: the only requester; if both request, the port ≠ `last`.
  - Register the winner's fields onto the `MEM_*` outputs, latch `grant`, set `last`=`grant`, go to ISSUE.
- **ISSUE (exactly one cycle):**
  - `MEM_Cmd`=1 and `P[grant]_Ack`=1; these are the only cycles either is high.
  - Next state: write goes to IDLE; read goes to WAIT_READ with the timeout counter cleared.
- **WAIT_READ:**
  - `P[grant]_DataReady` = `MEM_DataReady` (combinational); the other port's DataReady stays 0.
  - On `MEM_DataReady`, return to IDLE on the next edge.
  - Otherwise the counter increments. When it reaches `TIMEOUT` (nonzero), pulse `BusError` for one cycle, return to IDLE, and do not assert DataReady.
- **Field outputs:** `MEM_We/ByteEnable/Addr/DataOut` hold their last issued values outside ISSUE.
- **Spurious returns:** `MEM_DataReady` outside WAIT_READ is ignored; no `Px_DataReady` is asserted.
- **Dropped requests:** dropping `Px_Cmd` before Ack is illegal. If it happens while the port is not yet granted, the request is simply never issued.
- **Counter width:** clog2(`TIMEOUT`+1), saturating.

## Timing
- **Issue latency:** `Px_Cmd` high in cycle N with `MEM_Ready`=1 and state IDLE gives `MEM_Cmd` and `Px_Ack` in cycle N+1.
- **Write throughput:** at most one write every 2 cycles (ISSUE→IDLE→ISSUE).
- **Read occupancy:** 2 cycles plus memory latency. Data returned in cycle M is visible on `Px_DataIn/Px_DataReady` in cycle M; the next command can issue at M+2.
- **`MEM_Ready` low in IDLE:** stall, no grant. `last` is unchanged.
- **Mid-operation reset:** immediate return to IDLE with all outputs 0. A read in flight is abandoned; a later `MEM_DataReady` is ignored.
- **Same-port re-request:** a requester holding `Cmd` after its Ack is treated as a new request. With both ports requesting continuously, grants alternate 0,1,0,1.

## Test plan
- **Single read:** P1 read at 0x0000_1004, memory returns 0xDEADBEEF 3 cycles after `MEM_Cmd` -> `MEM_Cmd`/`P1_Ack` one cycle after request, `P1_DataReady`=1 with 0xDEADBEEF, `P0_DataReady`=0, `Busy` falls.
- **Contention from reset:** both ports request writes continuously from reset -> issue order P0,P1,P0,P1. `MEM_Cmd` on every second cycle; each `Px_Ack` paired with its own `Addr/DataOut`.
- **Backpressure:** `MEM_Ready`=0 for 5 cycles while P0 requests -> no `MEM_Cmd`. Issue occurs the cycle after `MEM_Ready` rises.
- **Timeout:** `TIMEOUT`=4, P0 read, memory silent -> `BusError` pulses 5 cycles after ISSUE, state IDLE, no `P0_DataReady`. A late `MEM_DataReady` is ignored.
- **Reset mid-read:** `Reset` asserted in WAIT_READ -> all outputs 0 asynchronously. After release, P0 wins a tie.
- **Spurious return:** `MEM_DataReady` pulse in IDLE -> no `Px_DataReady`, state unchanged.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the shared external memory port.
// The arbiter connects through the slave modport; requesters and the memory
// model connect through the master modport.
interface mem_arbiter_if;
   // Port 0 (instruction fetch)
   logic        p0_cmd;
   logic        p0_we;
   logic [1:0]  p0_byte_enable;
   logic [31:0] p0_addr;
   logic [31:0] p0_data_out;
   logic        p0_ack;
   logic [31:0] p0_data_in;
   logic        p0_data_ready;

   // Port 1 (load/store)
   logic        p1_cmd;
   logic        p1_we;
   logic [1:0]  p1_byte_enable;
   logic [31:0] p1_addr;
   logic [31:0] p1_data_out;
   logic        p1_ack;
   logic [31:0] p1_data_in;
   logic        p1_data_ready;

   // External memory port
   logic        mem_ready;
   logic        mem_cmd;
   logic        mem_we;
   logic [1:0]  mem_byte_enable;
   logic [31:0] mem_addr;
   logic [31:0] mem_data_out;
   logic [31:0] mem_data_in;
   logic        mem_data_ready;

   // Status
   logic        busy;
   logic        bus_error;

   modport slave (
      input  p0_cmd, p0_we, p0_byte_enable, p0_addr, p0_data_out,
      output p0_ack, p0_data_in, p0_data_ready,
      input  p1_cmd, p1_we, p1_byte_enable, p1_addr, p1_data_out,
      output p1_ack, p1_data_in, p1_data_ready,
      input  mem_ready, mem_data_in, mem_data_ready,
      output mem_cmd, mem_we, mem_byte_enable, mem_addr, mem_data_out,
      output busy, bus_error
   );

   modport master (
      output p0_cmd, p0_we, p0_byte_enable, p0_addr, p0_data_out,
      input  p0_ack, p0_data_in, p0_data_ready,
      output p1_cmd, p1_we, p1_byte_enable, p1_addr, p1_data_out,
      input  p1_ack, p1_data_in, p1_data_ready,
      output mem_ready, mem_data_in, mem_data_ready,
      input  mem_cmd, mem_we, mem_byte_enable, mem_addr, mem_data_out,
      input  busy, bus_error
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for the single external memory port.
// One registered command per grant; an outstanding read is tracked until data
// returns (routed to the granted port) or a timeout aborts it with bus_error.
module mem_arbiter #(
   parameter int unsigned Timeout = 255  // 0 disables the read timeout
) (
   input logic          clk_i,
   input logic          rst_i,
   mem_arbiter_if.slave bus_io
);

   // At least one bit even when the timeout is disabled.
   localparam int unsigned    CntW       = (Timeout == 0) ? 1 : $clog2(Timeout + 1);
   localparam logic [CntW-1:0] CntMax     = '1;
   localparam logic [CntW-1:0] TimeoutCnt = CntW'(Timeout);

   typedef enum logic [1:0] {StIdle, StIssue, StWaitRead} state_e;

   state_e          state_q;
   logic            grant_q;
   logic            last_q;
   logic [CntW-1:0] cnt_q;
   logic            mem_cmd_q;
   logic            mem_we_q;
   logic [1:0]      mem_be_q;
   logic [31:0]     mem_addr_q;
   logic [31:0]     mem_wdata_q;
   logic            p0_ack_q;
   logic            p1_ack_q;
   logic            bus_error_q;

   logic            req_any;
   logic            winner;
   logic            win_we;
   logic [1:0]      win_be;
   logic [31:0]     win_addr;
   logic [31:0]     win_wdata;
   logic [CntW-1:0] cnt_d;
   logic            timed_out;
   logic            wait_ready;

   // Round-robin winner selection and mux of the winner's command fields.
   always_comb begin
      req_any = bus_io.p0_cmd | bus_io.p1_cmd;
      if (bus_io.p0_cmd && bus_io.p1_cmd) begin
         winner = ~last_q;
      end else begin
         winner = bus_io.p1_cmd;
      end
      if (winner) begin
         win_we    = bus_io.p1_we;
         win_be    = bus_io.p1_byte_enable;
         win_addr  = bus_io.p1_addr;
         win_wdata = bus_io.p1_data_out;
      end else begin
         win_we    = bus_io.p0_we;
         win_be    = bus_io.p0_byte_enable;
         win_addr  = bus_io.p0_addr;
         win_wdata = bus_io.p0_data_out;
      end
   end

   // Saturating read-wait counter and abort condition.
   always_comb begin
      cnt_d     = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
      timed_out = (Timeout != 0) && (cnt_d == TimeoutCnt);
   end

   // Arbitration FSM with registered command, ack and error outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         grant_q     <= 1'b0;
         last_q      <= 1'b1;  // port 0 wins the first tie
         cnt_q       <= '0;
         mem_cmd_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= 2'b00;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         p0_ack_q    <= 1'b0;
         p1_ack_q    <= 1'b0;
         bus_error_q <= 1'b0;
      end else begin
         // Strobes default low; each is high for exactly one cycle.
         mem_cmd_q   <= 1'b0;
         p0_ack_q    <= 1'b0;
         p1_ack_q    <= 1'b0;
         bus_error_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (bus_io.mem_ready && req_any) begin
                  mem_we_q    <= win_we;
                  mem_be_q    <= win_be;
                  mem_addr_q  <= win_addr;
                  mem_wdata_q <= win_wdata;
                  mem_cmd_q   <= 1'b1;
                  p0_ack_q    <= ~winner;
                  p1_ack_q    <= winner;
                  grant_q     <= winner;
                  last_q      <= winner;
                  state_q     <= StIssue;
               end
            end
            StIssue: begin
               if (mem_we_q) begin
                  state_q <= StIdle;
               end else begin
                  cnt_q   <= '0;
                  state_q <= StWaitRead;
               end
            end
            StWaitRead: begin
               // Returned data wins over a coincident timeout.
               if (bus_io.mem_data_ready) begin
                  state_q <= StIdle;
               end else if (timed_out) begin
                  bus_error_q <= 1'b1;
                  state_q     <= StIdle;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Read completions are steered to the granted port only while waiting.
   always_comb begin
      wait_ready           = (state_q == StWaitRead) && bus_io.mem_data_ready;
      bus_io.p0_data_ready = wait_ready && !grant_q;
      bus_io.p1_data_ready = wait_ready && grant_q;
   end

   assign bus_io.p0_data_in      = bus_io.mem_data_in;
   assign bus_io.p1_data_in      = bus_io.mem_data_in;
   assign bus_io.p0_ack          = p0_ack_q;
   assign bus_io.p1_ack          = p1_ack_q;
   assign bus_io.mem_cmd         = mem_cmd_q;
   assign bus_io.mem_we          = mem_we_q;
   assign bus_io.mem_byte_enable = mem_be_q;
   assign bus_io.mem_addr        = mem_addr_q;
   assign bus_io.mem_data_out    = mem_wdata_q;
   assign bus_io.busy            = (state_q != StIdle);
   assign bus_io.bus_error       = bus_error_q;

   // Only one port is ever acked, and only alongside the command strobe.
   a_ack_onehot : assert property (@(posedge clk_i) disable iff (rst_i)
      !(bus_io.p0_ack && bus_io.p1_ack));
   a_ack_with_cmd : assert property (@(posedge clk_i) disable iff (rst_i)
      ((bus_io.p0_ack || bus_io.p1_ack) == bus_io.mem_cmd));

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter. A timeline model predicts, per grant, the
// cycles of ack/command, busy, read completion or bus error, and the memory
// side is driven from that same timeline.
module tb_mem_arbiter;

   localparam int unsigned Timeout = 4;
   localparam int          MaxCyc  = 4096;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mem_arbiter_if bus ();

   mem_arbiter #(.Timeout(Timeout)) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .bus_io (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Expected per-cycle outputs, indexed by absolute cycle number.
   bit          exp_cmd   [MaxCyc];
   bit          exp_berr  [MaxCyc];
   bit          exp_busy  [MaxCyc];
   bit          in_wait   [MaxCyc];
   bit          sched_mdr [MaxCyc];
   bit          exp_ack   [2][MaxCyc];
   bit          exp_dr    [2][MaxCyc];
   logic        f_we      [MaxCyc];
   logic [1:0]  f_be      [MaxCyc];
   logic [31:0] f_addr    [MaxCyc];
   logic [31:0] f_data    [MaxCyc];

   logic        cur_we;
   logic [1:0]  cur_be;
   logic [31:0] cur_addr;
   logic [31:0] cur_data;

   // Requester state.
   bit          pend    [2];
   logic        rq_we   [2];
   logic [1:0]  rq_be   [2];
   logic [31:0] rq_addr [2];
   logic [31:0] rq_data [2];

   int next_arb    = 0;
   bit last        = 1'b1;
   bit in_reset    = 1'b1;
   bit release_rst = 1'b0;

   // Stimulus knobs.
   int          req_pct [2];
   int          wr_pct, ready_pct, spur_pct, lat_fix;
   bit          fix_addr_en, fix_rdata_en;
   logic [31:0] fix_addr;
   logic        mrdy;
   logic [31:0] mdin;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int k = cyc; k < MaxCyc; k++) begin
         exp_cmd[k] = 0; exp_berr[k] = 0; exp_busy[k] = 0; in_wait[k] = 0;
         sched_mdr[k] = 0;
         exp_ack[0][k] = 0; exp_ack[1][k] = 0; exp_dr[0][k] = 0; exp_dr[1][k] = 0;
      end
      next_arb = 0;
      last     = 1'b1;
      pend[0]  = 0;
      pend[1]  = 0;
      cur_we = 1'b0; cur_be = 2'b00; cur_addr = 32'h0; cur_data = 32'h0;
   endtask

   // Decide the grant for cycle c and lay out its consequences on the timeline.
   task automatic model_cycle(input int c);
      int w, i, lat, d, e;
      if (in_reset || c < next_arb || !mrdy || !(pend[0] || pend[1])) return;
      if (pend[0] && pend[1]) w = last ? 0 : 1;
      else                    w = pend[1] ? 1 : 0;
      last = (w == 1);
      i = c + 1;
      exp_cmd[i]    = 1;
      exp_ack[w][i] = 1;
      f_we[i] = rq_we[w]; f_be[i] = rq_be[w]; f_addr[i] = rq_addr[w]; f_data[i] = rq_data[w];
      if (rq_we[w]) begin
         exp_busy[i] = 1;
         next_arb    = c + 2;
      end else begin
         lat = (lat_fix != 0) ? lat_fix : int'($urandom_range(Timeout + 2, 1));
         if (lat <= int'(Timeout)) begin
            d = i + lat;
            for (int k = i; k <= d; k++) exp_busy[k] = 1;
            for (int k = i + 1; k <= d; k++) in_wait[k] = 1;
            sched_mdr[d] = 1;
            exp_dr[w][d] = 1;
            next_arb     = d + 1;
         end else begin
            e = i + int'(Timeout) + 1;
            for (int k = i; k < e; k++) exp_busy[k] = 1;
            for (int k = i + 1; k < e; k++) in_wait[k] = 1;
            exp_berr[e]  = 1;
            sched_mdr[e] = 1;  // late return, must be ignored
            next_arb     = e;
         end
      end
   endtask

   task automatic check_cycle(input int c);
      if (exp_cmd[c]) begin
         cur_we = f_we[c]; cur_be = f_be[c]; cur_addr = f_addr[c]; cur_data = f_data[c];
      end
      check_eq($sformatf("c%0d mem_cmd", c), 32'(bus.mem_cmd), 32'(exp_cmd[c]));
      check_eq($sformatf("c%0d p0_ack", c), 32'(bus.p0_ack), 32'(exp_ack[0][c]));
      check_eq($sformatf("c%0d p1_ack", c), 32'(bus.p1_ack), 32'(exp_ack[1][c]));
      check_eq($sformatf("c%0d p0_dr", c), 32'(bus.p0_data_ready), 32'(exp_dr[0][c]));
      check_eq($sformatf("c%0d p1_dr", c), 32'(bus.p1_data_ready), 32'(exp_dr[1][c]));
      check_eq($sformatf("c%0d bus_error", c), 32'(bus.bus_error), 32'(exp_berr[c]));
      check_eq($sformatf("c%0d busy", c), 32'(bus.busy), 32'(exp_busy[c]));
      check_eq($sformatf("c%0d mem_we", c), 32'(bus.mem_we), 32'(cur_we));
      check_eq($sformatf("c%0d mem_be", c), 32'(bus.mem_byte_enable), 32'(cur_be));
      check_eq($sformatf("c%0d mem_addr", c), bus.mem_addr, cur_addr);
      check_eq($sformatf("c%0d mem_wdata", c), bus.mem_data_out, cur_data);
      if (exp_dr[0][c]) check_eq($sformatf("c%0d p0_rdata", c), bus.p0_data_in, mdin);
      if (exp_dr[1][c]) check_eq($sformatf("c%0d p1_rdata", c), bus.p1_data_in, mdin);
      if (fix_rdata_en && exp_dr[1][c])
         check_eq($sformatf("c%0d single_read", c), bus.p1_data_in, 32'hDEAD_BEEF);
   endtask

   task automatic check_zero(input string tag);
      check_eq({tag, " mem_cmd"}, 32'(bus.mem_cmd), 32'h0);
      check_eq({tag, " acks"}, 32'({bus.p0_ack, bus.p1_ack}), 32'h0);
      check_eq({tag, " drs"}, 32'({bus.p0_data_ready, bus.p1_data_ready}), 32'h0);
      check_eq({tag, " bus_error"}, 32'(bus.bus_error), 32'h0);
      check_eq({tag, " busy"}, 32'(bus.busy), 32'h0);
      check_eq({tag, " mem_we_be"}, 32'({bus.mem_we, bus.mem_byte_enable}), 32'h0);
      check_eq({tag, " mem_addr"}, bus.mem_addr, 32'h0);
      check_eq({tag, " mem_wdata"}, bus.mem_data_out, 32'h0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (release_rst) begin
         rst = 1'b0; in_reset = 1'b0; release_rst = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
         if (pend[p] && cyc > 0 && exp_ack[p][cyc-1]) pend[p] = 0;
         if (!pend[p] && !in_reset && int'($urandom_range(99)) < req_pct[p]) begin
            pend[p]    = 1;
            rq_we[p]   = int'($urandom_range(99)) < wr_pct;
            rq_be[p]   = 2'($urandom_range(3));
            rq_addr[p] = fix_addr_en ? fix_addr : $urandom;
            rq_data[p] = $urandom;
         end
      end
      mrdy = int'($urandom_range(99)) < ready_pct;
      mdin = fix_rdata_en ? 32'hDEAD_BEEF : $urandom;
      model_cycle(cyc);
      bus.p0_cmd = pend[0]; bus.p0_we = rq_we[0]; bus.p0_byte_enable = rq_be[0];
      bus.p0_addr = rq_addr[0]; bus.p0_data_out = rq_data[0];
      bus.p1_cmd = pend[1]; bus.p1_we = rq_we[1]; bus.p1_byte_enable = rq_be[1];
      bus.p1_addr = rq_addr[1]; bus.p1_data_out = rq_data[1];
      bus.mem_ready      = mrdy;
      bus.mem_data_in    = mdin;
      bus.mem_data_ready = sched_mdr[cyc] ||
                           (!in_wait[cyc] && int'($urandom_range(99)) < spur_pct);
      @(negedge clk);
      check_cycle(cyc);
      cyc++;
   endtask

   initial begin
      for (int p = 0; p < 2; p++) begin
         pend[p] = 0; rq_we[p] = 0; rq_be[p] = 0; rq_addr[p] = 0; rq_data[p] = 0;
      end
      bus.p0_cmd = 0; bus.p0_we = 0; bus.p0_byte_enable = 0; bus.p0_addr = 0;
      bus.p0_data_out = 0;
      bus.p1_cmd = 0; bus.p1_we = 0; bus.p1_byte_enable = 0; bus.p1_addr = 0;
      bus.p1_data_out = 0;
      bus.mem_ready = 0; bus.mem_data_in = 0; bus.mem_data_ready = 0;
      mrdy = 0; mdin = 0;
      fix_addr_en = 0; fix_rdata_en = 0; fix_addr = 0;
      spur_pct = 0; lat_fix = 0;
      model_clear();

      // Reset state.
      #2 check_zero("reset");
      repeat (2) @(negedge clk);
      check_zero("reset_hold");
      release_rst = 1'b1;

      // Both ports write continuously from reset: grants alternate P0,P1,...
      req_pct[0] = 100; req_pct[1] = 100; wr_pct = 100; ready_pct = 100;
      repeat (12) step();
      req_pct[0] = 0; req_pct[1] = 0;
      repeat (8) step();

      // Single read on P1 with a fixed address, data 3 cycles after the command.
      req_pct[1] = 100; wr_pct = 0; lat_fix = 3;
      fix_addr_en = 1; fix_addr = 32'h0000_1004; fix_rdata_en = 1;
      step();
      req_pct[1] = 0;
      repeat (8) step();
      fix_addr_en = 0; fix_rdata_en = 0;

      // Backpressure: memory not ready for 5 cycles while P0 requests.
      ready_pct = 0; req_pct[0] = 100; wr_pct = 100; lat_fix = 0;
      repeat (5) step();
      req_pct[0] = 0; ready_pct = 100;
      repeat (4) step();

      // Silent memory: P0 read times out, then a late return is ignored.
      wr_pct = 0; req_pct[0] = 100; lat_fix = int'(Timeout) + 1;
      step();
      req_pct[0] = 0;
      repeat (10) step();

      // Spurious returns while idle.
      spur_pct = 100;
      repeat (4) step();
      spur_pct = 0;

      // Reset in the middle of a read.
      req_pct[0] = 100; wr_pct = 0; lat_fix = int'(Timeout) + 2;
      for (int i = 0; i < 20 && !in_wait[cyc-1]; i++) step();
      check_eq("reach_wait_read busy", 32'(bus.busy), 32'h1);
      #2 rst = 1'b1;
      #1 check_zero("async_reset");
      model_clear();
      in_reset = 1'b1;
      req_pct[0] = 100; req_pct[1] = 100; wr_pct = 100; spur_pct = 100;
      repeat (3) step();
      release_rst = 1'b1;
      spur_pct = 0;
      repeat (8) step();

      // Mixed random traffic.
      req_pct[0] = 60; req_pct[1] = 60; wr_pct = 50; ready_pct = 80; spur_pct = 10;
      lat_fix = 0;
      repeat (1500) step();
      req_pct[0] = 0; req_pct[1] = 0; spur_pct = 0;
      repeat (16) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
